// File: rtl/mips_ctrl_alu_dmem.sv
// ID-stage decoder, EX-stage ALU and MEM-stage word-addressed data memory in one cluster.
// Optional macro ALU_OVF_EN adds the alu_ovf signed-overflow output.
module mips_ctrl_alu_dmem #(
    parameter int DMEM_DEPTH = 128,
    parameter int DMEM_AW    = 7
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    output logic               JtoPC,
    output logic               Branch,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               ALUSrc,
    output logic               MemWrite,
    output logic               MemRead,
    output logic               MemtoReg,
    output logic [3:0]         ALUOp,
    input  logic [3:0]         alu_op,
    input  logic [31:0]        alu_a,
    input  logic [31:0]        alu_b,
    output logic [31:0]        alu_result,
    output logic               alu_zero,
`ifdef ALU_OVF_EN
    output logic               alu_ovf,
`endif
    input  logic               mem_we,
    input  logic               mem_re,
    input  logic [DMEM_AW-1:0] mem_addr,
    input  logic [31:0]        mem_wdata,
    output logic [31:0]        mem_rdata
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_LUI  = 4'b1000;
    localparam logic [3:0] OP_BEQ  = 4'b1001;

    // Decoder
    always_comb begin
        JtoPC    = 1'b0;
        Branch   = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        ALUSrc   = 1'b0;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        MemtoReg = 1'b0;
        ALUOp    = OP_ADD;
        case (opcode)
            6'b000000: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                case (funct)
                    6'b100000: ALUOp = OP_ADD;
                    6'b100010: ALUOp = OP_SUB;
                    6'b100100: ALUOp = OP_AND;
                    6'b100101: ALUOp = OP_OR;
                    6'b100110: ALUOp = OP_XOR;
                    6'b100111: ALUOp = OP_NOR;
                    6'b101010: ALUOp = OP_SLT;
                    6'b101011: ALUOp = OP_SLTU;
                    default: begin
                        // unsupported funct behaves as a nop
                        RegWrite = 1'b0;
                        RegDst   = 1'b0;
                    end
                endcase
            end
            6'b100011: begin
                RegWrite = 1'b1;
                ALUSrc   = 1'b1;
                MemRead  = 1'b1;
                MemtoReg = 1'b1;
            end
            6'b101011: begin
                ALUSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            6'b000100: begin
                Branch = 1'b1;
                ALUOp  = OP_BEQ;
            end
            6'b000010: JtoPC = 1'b1;
            6'b001000: begin
                RegWrite = 1'b1;
                ALUSrc   = 1'b1;
            end
            6'b001100: begin
                RegWrite = 1'b1;
                ALUSrc   = 1'b1;
                ALUOp    = OP_AND;
            end
            6'b001101: begin
                RegWrite = 1'b1;
                ALUSrc   = 1'b1;
                ALUOp    = OP_OR;
            end
            6'b001010: begin
                RegWrite = 1'b1;
                ALUSrc   = 1'b1;
                ALUOp    = OP_SLT;
            end
            6'b001111: begin
                RegWrite = 1'b1;
                ALUSrc   = 1'b1;
                ALUOp    = OP_LUI;
            end
            default: ;
        endcase
    end

    // ALU
    logic [31:0] sum;
    logic [31:0] diff;
    assign sum  = alu_a + alu_b;
    assign diff = alu_a - alu_b;

    always_comb begin
        alu_result = '0;
        case (alu_op)
            OP_ADD:         alu_result = sum;
            OP_SUB, OP_BEQ: alu_result = diff;
            OP_AND:         alu_result = alu_a & alu_b;
            OP_OR:          alu_result = alu_a | alu_b;
            OP_XOR:         alu_result = alu_a ^ alu_b;
            OP_NOR:         alu_result = ~(alu_a | alu_b);
            OP_SLT:         alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
            OP_SLTU:        alu_result = {31'b0, alu_a < alu_b};
            OP_LUI:         alu_result = alu_b << 16;
            default:        alu_result = '0;
        endcase
    end

    assign alu_zero = (alu_result == 32'd0);

`ifdef ALU_OVF_EN
    always_comb begin
        alu_ovf = 1'b0;
        case (alu_op)
            OP_ADD:         alu_ovf = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
            OP_SUB, OP_BEQ: alu_ovf = (alu_a[31] != alu_b[31]) && (diff[31] != alu_a[31]);
            default:        alu_ovf = 1'b0;
        endcase
    end
`endif

    // Data memory: reset wipes every word, so reads during reset are forced to 0 as well
    logic [31:0] mem [DMEM_DEPTH];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DMEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    assign mem_rdata = (mem_re && !RST) ? mem[mem_addr] : 32'd0;

endmodule

// File: tb/tb_mips_ctrl_alu_dmem.sv
// Scoreboard bench for mips_ctrl_alu_dmem: decoder table, directed and random ALU ops, memory and reset.
module tb_mips_ctrl_alu_dmem;

    logic        CLK = 1'b0;
    logic        RST;
    logic [5:0]  opcode, funct;
    logic        JtoPC, Branch, RegWrite, RegDst, ALUSrc, MemWrite, MemRead, MemtoReg;
    logic [3:0]  ALUOp;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_zero;
`ifdef ALU_OVF_EN
    logic        alu_ovf;
`endif
    logic        mem_we, mem_re;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    mips_ctrl_alu_dmem #(.DMEM_DEPTH(128), .DMEM_AW(7)) dut (
        .CLK(CLK), .RST(RST),
        .opcode(opcode), .funct(funct),
        .JtoPC(JtoPC), .Branch(Branch), .RegWrite(RegWrite), .RegDst(RegDst),
        .ALUSrc(ALUSrc), .MemWrite(MemWrite), .MemRead(MemRead), .MemtoReg(MemtoReg),
        .ALUOp(ALUOp),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
`ifdef ALU_OVF_EN
        .alu_ovf(alu_ovf),
`endif
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic pop_check(input string tag, input logic [31:0] got);
        if (exp_q.size() == 0) begin
            check_eq({tag, "_noexp"}, got, 32'hxxxx_xxxx);
        end else begin
            check_eq(tag, got, exp_q.pop_front());
        end
    endtask

    // reference ALU written independently of the design's structure
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic lt;
        case (op)
            4'd0: ref_alu = a + b;
            4'd1, 4'd9: ref_alu = a + ~b + 32'd1;
            4'd2: ref_alu = a & b;
            4'd3: ref_alu = a | b;
            4'd4: ref_alu = a ^ b;
            4'd5: ref_alu = ~a & ~b;
            4'd6: begin
                lt = (a[31] != b[31]) ? a[31] : (a < b);
                ref_alu = {31'b0, lt};
            end
            4'd7: ref_alu = (a < b) ? 32'd1 : 32'd0;
            4'd8: ref_alu = {b[15:0], 16'h0000};
            default: ref_alu = 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] dec_word();
        return {20'd0, JtoPC, Branch, RegWrite, RegDst, ALUSrc, MemWrite, MemRead, MemtoReg, ALUOp};
    endfunction

    // driver tasks
    task automatic drive_dec(input string tag, input logic [5:0] op, input logic [5:0] fn, input logic [11:0] exp);
        opcode = op;
        funct  = fn;
        push_exp({20'd0, exp});
        #1;
        pop_check(tag, dec_word());
    endtask

    task automatic drive_alu(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_r, input logic exp_z);
        alu_op = op;
        alu_a  = a;
        alu_b  = b;
        push_exp(exp_r);
        push_exp({31'b0, exp_z});
        #1;
        pop_check({tag, "_res"}, alu_result);
        pop_check({tag, "_zero"}, {31'b0, alu_zero});
    endtask

    task automatic mem_write(input logic [6:0] a, input logic [31:0] d);
        @(negedge CLK);
        mem_we = 1'b1; mem_re = 1'b0; mem_addr = a; mem_wdata = d;
        @(negedge CLK);
        mem_we = 1'b0;
    endtask

    task automatic mem_read(input string tag, input logic [6:0] a, input logic [31:0] exp);
        mem_re = 1'b1; mem_addr = a;
        push_exp(exp);
        #1;
        pop_check(tag, mem_rdata);
    endtask

    initial begin
        RST = 1'b1;
        opcode = '0; funct = '0; alu_op = '0; alu_a = '0; alu_b = '0;
        mem_we = 1'b0; mem_re = 1'b0; mem_addr = '0; mem_wdata = '0;
        repeat (2) @(negedge CLK);
        mem_read("rst_read", 7'h05, 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        mem_read("post_rst_read", 7'h05, 32'd0);

        // decoder
        drive_dec("dec_lw",    6'b100011, 6'b000000, 12'b001010110000);
        drive_dec("dec_sw",    6'b101011, 6'b000000, 12'b000011000000);
        drive_dec("dec_beq",   6'b000100, 6'b000000, 12'b010000001001);
        drive_dec("dec_j",     6'b000010, 6'b000000, 12'b100000000000);
        drive_dec("dec_slt",   6'b000000, 6'b101010, 12'b001100000110);
        drive_dec("dec_sub",   6'b000000, 6'b100010, 12'b001100000001);
        drive_dec("dec_nor",   6'b000000, 6'b100111, 12'b001100000101);
        drive_dec("dec_badfn", 6'b000000, 6'b000000, 12'b000000000000);
        drive_dec("dec_lui",   6'b001111, 6'b000000, 12'b001010001000);
        drive_dec("dec_ori",   6'b001101, 6'b000000, 12'b001010000011);
        drive_dec("dec_slti",  6'b001010, 6'b000000, 12'b001010000110);
        drive_dec("dec_bad",   6'b111111, 6'b101010, 12'b000000000000);

        // directed ALU
        drive_alu("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
        drive_alu("sub_neg",  4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0);
        drive_alu("slt",      4'd6, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        drive_alu("sltu",     4'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
        drive_alu("lui",      4'd8, 32'd0, 32'h0000_1234, 32'h1234_0000, 1'b0);
        drive_alu("beq_eq",   4'd9, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd0, 1'b1);
        drive_alu("beq_ne",   4'd9, 32'd3, 32'd4, 32'hFFFF_FFFF, 1'b0);
        drive_alu("nor",      4'd5, 32'hF0F0_0000, 32'h0F0F_0000, 32'h0000_FFFF, 1'b0);
        drive_alu("code_f",   4'd15, 32'h1234_5678, 32'h1, 32'd0, 1'b1);
`ifdef ALU_OVF_EN
        drive_alu("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0);
        push_exp(32'd1); pop_check("ovf_add", {31'b0, alu_ovf});
        drive_alu("sub_ovf", 4'd1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0);
        push_exp(32'd1); pop_check("ovf_sub", {31'b0, alu_ovf});
        drive_alu("and_ovf", 4'd2, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        push_exp(32'd0); pop_check("ovf_and", {31'b0, alu_ovf});
`endif

        // random ALU against reference
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b, r;
            op = 4'($urandom_range(0, 15));
            a  = $urandom();
            b  = (i % 5 == 0) ? a : $urandom();
            r  = ref_alu(op, a, b);
            drive_alu("alu_rand", op, a, b, r, r == 32'd0);
        end

        // memory store / load
        mem_write(7'h05, 32'hCAFE_F00D);
        mem_read("ld_05", 7'h05, 32'hCAFE_F00D);
        mem_re = 1'b0;
        push_exp(32'd0); #1; pop_check("re_off", mem_rdata);
        mem_write(7'h7F, 32'h0BAD_F00D);
        mem_read("ld_7f", 7'h7F, 32'h0BAD_F00D);
        mem_read("ld_05_again", 7'h05, 32'hCAFE_F00D);

        // same-cycle read/write: old value before the edge, new value after
        @(negedge CLK);
        mem_we = 1'b1; mem_re = 1'b1; mem_addr = 7'h05; mem_wdata = 32'h1;
        push_exp(32'hCAFE_F00D); #1; pop_check("rw_before", mem_rdata);
        @(posedge CLK); #1;
        push_exp(32'h1); pop_check("rw_after", mem_rdata);
        @(negedge CLK);
        mem_we = 1'b0;

        // reset mid-cycle
        mem_write(7'h00, 32'h1111_2222);
        mem_read("ld_00", 7'h00, 32'h1111_2222);
        #2;
        RST = 1'b1;
        mem_read("rst_00", 7'h00, 32'd0);
        mem_read("rst_7f", 7'h7F, 32'd0);
        @(negedge CLK);
        mem_we = 1'b1; mem_addr = 7'h03; mem_wdata = 32'h5555_AAAA;
        @(negedge CLK);
        mem_we = 1'b0;
        RST = 1'b0;
        mem_read("wr_blocked", 7'h03, 32'd0);
        mem_read("post_rst_00", 7'h00, 32'd0);
        mem_read("post_rst_7f", 7'h7F, 32'd0);
        mem_write(7'h03, 32'h0000_0042);
        mem_read("ld_03", 7'h03, 32'h0000_0042);

        // final report
        if (exp_q.size() != 0) begin
            check_eq("exp_q_drained", exp_q.size(), 32'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
